// File: rtl/lic_acc_region_evt_ctrl_if.sv
// Bus between the accelerator region (master side) and the event/busy controller (slave side).
// With LIC_ACC_EVT_OVF_EN defined the bus also carries the sticky overflow flags.
interface lic_acc_region_evt_ctrl_if #(
    parameter int NB_CORES    = 2,
    parameter int NB_HWPE     = 4,
    parameter int BUSY_HOLD_W = 4,
    parameter int CORE_SEL_W  = (NB_CORES > 1) ? $clog2(NB_CORES) : 1
);
    logic [NB_HWPE*2-1:0]          acc_evt_i;
    logic [NB_HWPE-1:0]            acc_busy_i;
    logic [NB_HWPE-1:0]            acc_en_i;
    logic [NB_HWPE*CORE_SEL_W-1:0] acc_core_sel_i;
    logic [BUSY_HOLD_W-1:0]        busy_hold_i;
    logic [NB_CORES*2-1:0]         evt_o;
    logic                          busy_o;
    logic [NB_CORES*2-1:0]         evt_pending_o;
`ifdef LIC_ACC_EVT_OVF_EN
    logic [NB_CORES*2-1:0]         evt_ovf_o;

    modport master (
        output acc_evt_i, acc_busy_i, acc_en_i, acc_core_sel_i, busy_hold_i,
        input  evt_o, busy_o, evt_pending_o, evt_ovf_o
    );
    modport slave (
        input  acc_evt_i, acc_busy_i, acc_en_i, acc_core_sel_i, busy_hold_i,
        output evt_o, busy_o, evt_pending_o, evt_ovf_o
    );
`else
    modport master (
        output acc_evt_i, acc_busy_i, acc_en_i, acc_core_sel_i, busy_hold_i,
        input  evt_o, busy_o, evt_pending_o
    );
    modport slave (
        input  acc_evt_i, acc_busy_i, acc_en_i, acc_core_sel_i, busy_hold_i,
        output evt_o, busy_o, evt_pending_o
    );
`endif
endinterface

// File: rtl/lic_acc_region_evt_ctrl.sv
// Event routing, per-core pending queues and busy hold-off for a LIC accelerator region.
// Optional sticky overflow flags are enabled with the macro LIC_ACC_EVT_OVF_EN.
module lic_acc_region_evt_ctrl #(
    parameter int NB_CORES    = 2,
    parameter int NB_HWPE     = 4,
    parameter int EVT_CNT_W   = 4,
    parameter int BUSY_HOLD_W = 4,
    parameter int CORE_SEL_W  = (NB_CORES > 1) ? $clog2(NB_CORES) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        test_mode,
    lic_acc_region_evt_ctrl_if.slave    bus
);

    localparam int NB_CNT = NB_CORES * 2;
    localparam int SUM_W  = EVT_CNT_W + $clog2(NB_HWPE + 1);
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'((1 << EVT_CNT_W) - 1);

    logic [EVT_CNT_W-1:0]   cnt_q [NB_CNT];
    logic [EVT_CNT_W-1:0]   cnt_d [NB_CNT];
    logic [SUM_W-1:0]       inc   [NB_CNT];
    logic [SUM_W-1:0]       sum   [NB_CNT];
    logic [NB_CNT-1:0]      sat;
    logic [NB_CNT-1:0]      evt_q;
    logic [NB_CNT-1:0]      pending;
    logic [BUSY_HOLD_W-1:0] hold_q;
    logic [BUSY_HOLD_W-1:0] hold_d;
    logic                   busy_q;
    logic                   busy_d;
    logic                   agg_busy;

    // Routing: a select value matching no core drops the event.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        for (int i = 0; i < NB_CNT; i++) inc[i] = '0;
        for (int a = 0; a < NB_HWPE; a++) begin
            for (int l = 0; l < 2; l++) begin
                if (bus.acc_en_i[a] && bus.acc_evt_i[2*a+l]) begin
                    for (int c = 0; c < NB_CORES; c++) begin
                        if (bus.acc_core_sel_i[a*CORE_SEL_W +: CORE_SEL_W] == CORE_SEL_W'(c))
                            inc[2*c+l] = inc[2*c+l] + SUM_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NB_CNT; i++) begin
            pending[i] = (cnt_q[i] != '0);
            sum[i]     = SUM_W'(cnt_q[i]) + inc[i] - SUM_W'(pending[i]);
            sat[i]     = (sum[i] > CNT_MAX);
            cnt_d[i]   = sat[i] ? CNT_MAX[EVT_CNT_W-1:0] : sum[i][EVT_CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the counter array is reset explicitly; a reset mid-replay must discard every queued event.
            for (int i = 0; i < NB_CNT; i++) cnt_q[i] <= '0;
            evt_q <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments so all registers update from the same pre-edge values.
            for (int i = 0; i < NB_CNT; i++) cnt_q[i] <= cnt_d[i];
            evt_q <= pending;
        end
    end

    // Busy stays asserted for busy_hold_i cycles after the aggregate falls.
    assign agg_busy = |(bus.acc_busy_i & bus.acc_en_i);

    always_comb begin
        hold_d = hold_q;
        if (agg_busy)
            hold_d = bus.busy_hold_i;
        else if (hold_q != '0)
            hold_d = hold_q - BUSY_HOLD_W'(1);
        busy_d = agg_busy || (hold_q != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            busy_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            busy_q <= busy_d;
        end
    end

`ifdef LIC_ACC_EVT_OVF_EN
    logic [NB_CNT-1:0] ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= '0;
        else        ovf_q <= ovf_q | sat;
    end

    assign bus.evt_ovf_o = ovf_q;
`endif

    assign bus.evt_o         = evt_q;
    assign bus.evt_pending_o = pending;
    assign bus.busy_o        = busy_q | test_mode;

endmodule

// File: tb/tb_lic_acc_region_evt_ctrl.sv
// Directed bench: u_dut1 uses default parameters, u_dut2 uses NB_CORES=3 and EVT_CNT_W=2.
module tb_lic_acc_region_evt_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic test_mode;
    logic test_mode2;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   pulses;

    always #5 clk = ~clk;

    lic_acc_region_evt_ctrl_if #(.NB_CORES(2), .NB_HWPE(4), .BUSY_HOLD_W(4), .CORE_SEL_W(1)) bus1 ();
    lic_acc_region_evt_ctrl_if #(.NB_CORES(3), .NB_HWPE(4), .BUSY_HOLD_W(4), .CORE_SEL_W(2)) bus2 ();

    lic_acc_region_evt_ctrl #(
        .NB_CORES(2), .NB_HWPE(4), .EVT_CNT_W(4), .BUSY_HOLD_W(4), .CORE_SEL_W(1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .test_mode(test_mode), .bus(bus1.slave)
    );

    lic_acc_region_evt_ctrl #(
        .NB_CORES(3), .NB_HWPE(4), .EVT_CNT_W(2), .BUSY_HOLD_W(4), .CORE_SEL_W(2)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .test_mode(test_mode2), .bus(bus2.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_all();
        bus1.acc_evt_i = '0; bus1.acc_busy_i = '0; bus1.acc_en_i = '0;
        bus1.acc_core_sel_i = '0; bus1.busy_hold_i = '0;
        bus2.acc_evt_i = '0; bus2.acc_busy_i = '0; bus2.acc_en_i = '0;
        bus2.acc_core_sel_i = '0; bus2.busy_hold_i = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; test_mode = 1'b0; test_mode2 = 1'b0;
        idle_all();
        repeat (2) step();
        check("rst_evt1",  bus1.evt_o, 0);
        check("rst_pend1", bus1.evt_pending_o, 0);
        check("rst_busy1", bus1.busy_o, 0);
        check("rst_evt2",  bus2.evt_o, 0);
        rst_n = 1'b1;
        step();

        // Single event: acc 2 -> core 1, line 0 (evt_o bit 2)
        bus1.acc_en_i = 4'b0100; bus1.acc_core_sel_i = 4'b0100; bus1.acc_evt_i = 8'h10;
        step();
        bus1.acc_evt_i = '0;
        check("single_pend_t1", bus1.evt_pending_o, 4'b0100);
        check("single_evt_t1",  bus1.evt_o, 0);
        step();
        check("single_evt_t2",  bus1.evt_o, 4'b0100);
        check("single_pend_t2", bus1.evt_pending_o, 0);
        step();
        check("single_evt_t3",  bus1.evt_o, 0);

        // Collision: four accs on line 1 of core 0 in one cycle
        bus1.acc_en_i = 4'hF; bus1.acc_core_sel_i = 4'h0; bus1.acc_evt_i = 8'hAA;
        step();
        bus1.acc_evt_i = '0;
        for (int k = 1; k <= 6; k++) begin
            check($sformatf("coll_evt_%0d", k),  bus1.evt_o, (k >= 2 && k <= 5) ? 2 : 0);
            check($sformatf("coll_pend_%0d", k), bus1.evt_pending_o, (k <= 4) ? 2 : 0);
            step();
        end

        // Masking: acc 1 disabled (event and busy ignored), acc 0 -> core 1 line 0
        bus1.acc_en_i = 4'b1101; bus1.acc_core_sel_i = 4'b0001;
        bus1.acc_evt_i = 8'h05; bus1.acc_busy_i = 4'b0010; bus1.busy_hold_i = '0;
        step();
        bus1.acc_evt_i = '0;
        check("mask_pend_t1", bus1.evt_pending_o, 4'b0100);
        check("mask_busy_t1", bus1.busy_o, 0);
        step();
        check("mask_evt_t2",  bus1.evt_o, 4'b0100);
        check("mask_busy_t2", bus1.busy_o, 0);
        step();
        check("mask_evt_t3",  bus1.evt_o, 0);
        check("mask_pend_t3", bus1.evt_pending_o, 0);
        bus1.acc_busy_i = '0;

        // Out-of-range select on dut2: sel=3 with 3 cores
        bus2.acc_en_i = 4'b0001; bus2.acc_core_sel_i = 8'h03; bus2.acc_evt_i = 8'h02;
        step();
        bus2.acc_evt_i = '0;
        for (int k = 1; k <= 3; k++) begin
            check($sformatf("range_evt_%0d", k),  bus2.evt_o, 0);
            check($sformatf("range_pend_%0d", k), bus2.evt_pending_o, 0);
`ifdef LIC_ACC_EVT_OVF_EN
            check($sformatf("range_ovf_%0d", k),  bus2.evt_ovf_o, 0);
`endif
            step();
        end

        // Saturation on dut2 (max 3): four events on core 0 line 0 in one cycle -> 3 pulses
        bus2.acc_en_i = 4'hF; bus2.acc_core_sel_i = 8'h00; bus2.acc_evt_i = 8'h55;
        step();
        bus2.acc_evt_i = '0;
        check("sat_pend_t1", bus2.evt_pending_o, 6'b000001);
        pulses = 0;
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("sat_evt_%0d", k), bus2.evt_o, (k >= 2 && k <= 4) ? 1 : 0);
            if (bus2.evt_o[0]) pulses++;
            step();
        end
        check("sat_pulses", pulses, 3);
`ifdef LIC_ACC_EVT_OVF_EN
        check("sat_ovf", bus2.evt_ovf_o, 6'b000001);
        repeat (3) step();
        check("sat_ovf_sticky", bus2.evt_ovf_o, 6'b000001);
`endif

        // Busy hold-off: agg high for 10 cycles, hold 5 -> busy high at k=1..15
        bus1.acc_en_i = 4'hF; bus1.busy_hold_i = 4'd5; bus1.acc_busy_i = 4'b0001;
        for (int k = 0; k <= 16; k++) begin
            check($sformatf("busy_hold_%0d", k), bus1.busy_o, (k >= 1 && k <= 15) ? 1 : 0);
            if (k == 10) bus1.acc_busy_i = '0;
            step();
        end

        // Zero hold: busy falls one cycle after agg falls
        bus1.busy_hold_i = '0; bus1.acc_busy_i = 4'b1000;
        step();
        bus1.acc_busy_i = '0;
        check("busy_h0_t1", bus1.busy_o, 1);
        step();
        check("busy_h0_t2", bus1.busy_o, 0);

        // test_mode forces busy combinationally
        test_mode = 1'b1;
        #1;
        check("tmode_on", bus1.busy_o, 1);
        step();
        check("tmode_hold", bus1.busy_o, 1);
        test_mode = 1'b0;
        #1;
        check("tmode_off", bus1.busy_o, 0);
        step();

        // Reset mid-replay: 6 events queued on core 0 line 0, reset after 2 pulses
        bus1.acc_en_i = 4'hF; bus1.acc_core_sel_i = 4'h0; bus1.busy_hold_i = 4'd3;
        bus1.acc_busy_i = 4'b0001; bus1.acc_evt_i = 8'h15;
        step();
        step();
        bus1.acc_evt_i = '0;
        check("rmid_evt_p1", bus1.evt_o, 1);
        step();
        check("rmid_evt_p2", bus1.evt_o, 1);
        check("rmid_busy",   bus1.busy_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rmid_evt_rst",  bus1.evt_o, 0);
        check("rmid_pend_rst", bus1.evt_pending_o, 0);
        check("rmid_busy_rst", bus1.busy_o, 0);
`ifdef LIC_ACC_EVT_OVF_EN
        check("rmid_ovf_rst",  bus2.evt_ovf_o, 0);
`endif
        bus1.acc_busy_i = '0;
        step();
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("rmid_post_evt_%0d", k),  bus1.evt_o, 0);
            check($sformatf("rmid_post_pend_%0d", k), bus1.evt_pending_o, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
